// File: rtl/ch2_cnt_ctrl.sv
// ---------------------------------------------------------------------------
// ch2_cnt_ctrl -- two-requester arbiter for one shared 3-bit run counter.
//
// A requester raises its req bit and holds it until it sees its done bit.
// The arbiter grants the counter to one requester, round-robin on ties. It
// latches that requester's terminal count, then counts q from 0 up to the
// terminal count. On completion it pulses done[owner] for one cycle. If the
// owner drops req mid-run, the run is aborted with no done pulse.
//
// All flops update on the falling edge of clk.
//
// Optional feature macro: CNT_PAUSE_EN
//   When defined, the pause input exists. pause=1 freezes q and the
//   terminal-count check while in RUN. An abort still takes priority.
//
// Ports
//   clk   in   1  clock (falling-edge active)
//   rst   in   1  asynchronous, active-high reset
//   req   in   2  per-requester run request, level-sensitive
//   tc0   in   3  terminal count for requester 0, sampled at grant
//   tc1   in   3  terminal count for requester 1, sampled at grant
//   pause in   1  count freeze (only with CNT_PAUSE_EN)
//   gnt   out  2  one-hot counter owner, 2'b00 when unowned
//   q     out  3  shared counter value
//   busy  out  1  high while in RUN
//   done  out  2  one-cycle completion pulse per requester
// ---------------------------------------------------------------------------
module ch2_cnt_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] tc0,
  input  logic [2:0] tc1,
`ifdef CNT_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] gnt,
  output logic [2:0] q,
  output logic       busy,
  output logic [1:0] done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] q_n;
  logic [2:0] tcl, tcl_n;
  logic [1:0] gnt_n, done_n;
  logic       busy_n;
  logic       last, last_n;   // index of the requester served most recently
  logic       win;            // requester that wins arbitration in IDLE
  logic       owner;          // requester currently holding the counter
  logic       stall;

`ifdef CNT_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  // On a tie the requester not served last wins. Otherwise the sole
  // requester wins.
  assign win   = (req == 2'b11) ? ~last : req[1];
  assign owner = gnt[1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= 3'd0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      tcl   <= 3'd0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      q     <= q_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= busy_n;
      tcl   <= tcl_n;
      last  <= last_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    q_n     = q;
    gnt_n   = gnt;
    done_n  = 2'b00;
    busy_n  = busy;
    tcl_n   = tcl;
    last_n  = last;

    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_n   = win ? 2'b10 : 2'b01;
          q_n     = 3'd0;
          tcl_n   = win ? tc1 : tc0;
          last_n  = win;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end

      RUN: begin
        if (!req[owner]) begin
          // Owner withdrew: abandon the run silently.
          gnt_n   = 2'b00;
          q_n     = 3'd0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (stall) begin
          q_n = q;
        end else if (q == tcl) begin
          // Terminal count reached. Hold q, so it never wraps past 7.
          gnt_n         = 2'b00;
          done_n[owner] = 1'b1;
          busy_n        = 1'b0;
          state_n       = DONE_ST;
        end else begin
          q_n = q + 3'd1;
        end
      end

      DONE_ST: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ch2_cnt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ch2_cnt_ctrl -- scoreboard bench for ch2_cnt_ctrl.
// Stimulus drives one falling edge per step and queues the hand-computed
// {gnt, q, busy, done} expected after that edge. A monitor pops the queue
// on the following rising edge and compares.
// ---------------------------------------------------------------------------
module tb_ch2_cnt_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [2:0] tc0, tc1;
  logic       pause;
  logic [1:0] gnt;
  logic [2:0] q;
  logic       busy;
  logic [1:0] done;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ch2_cnt_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .tc0  (tc0),
    .tc1  (tc1),
`ifdef CNT_PAUSE_EN
    .pause(pause),
`endif
    .gnt  (gnt),
    .q    (q),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ex(input logic [1:0] g, input logic [2:0] qv,
                                    input logic b, input logic [1:0] d);
    return {g, qv, b, d};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    logic [1:0] ag, eg, ad, ed;
    logic [2:0] aq, eq;
    logic       ab, eb;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      {ag, aq, ab, ad} = act;
      {eg, eq, eb, ed} = exp;
      $display("FAIL %s: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
               name, ag, aq, ab, ad, eg, eq, eb, ed);
    end
  endtask

  // Apply req, let one falling edge happen, queue what must follow it.
  task automatic step(input string name, input logic [1:0] r, input logic [7:0] e);
    exp_t item;
    req = r;
    @(negedge clk);
    item.name = name;
    item.exp  = e;
    sb.push_back(item);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t item;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        check(item.name, {gnt, q, busy, done}, item.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 2'b00; tc0 = 3'd0; tc1 = 3'd0; pause = 1'b0;
    #2;
    check("reset_state", {gnt, q, busy, done}, ex(2'b00, 3'd0, 1'b0, 2'b00));
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Single run on requester 0, TC0=3. tc0 changes mid-run without effect.
    tc0 = 3'd3;
    step("r0_grant", 2'b01, ex(2'b01, 3'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) tc0 = 3'd7;
      step("r0_count", 2'b01, ex(2'b01, 3'(i), 1'b1, 2'b00));
    end
    step("r0_done",   2'b01, ex(2'b00, 3'd3, 1'b0, 2'b01));
    step("r0_donest", 2'b00, ex(2'b00, 3'd3, 1'b0, 2'b00));
    step("r0_idle",   2'b00, ex(2'b00, 3'd3, 1'b0, 2'b00));

    // Requester 1 with TC1=0: a single RUN cycle at q=0.
    tc1 = 3'd0;
    step("r1_tc0_grant", 2'b10, ex(2'b10, 3'd0, 1'b1, 2'b00));
    step("r1_tc0_done",  2'b10, ex(2'b00, 3'd0, 1'b0, 2'b10));
    step("r1_tc0_dst",   2'b00, ex(2'b00, 3'd0, 1'b0, 2'b00));

    // Both held for two runs: r0 (TC0=2), then r1 (TC1=5).
    tc0 = 3'd2; tc1 = 3'd5;
    step("rr_grant0", 2'b11, ex(2'b01, 3'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 2; i++)
      step("rr_count0", 2'b11, ex(2'b01, 3'(i), 1'b1, 2'b00));
    step("rr_done0", 2'b11, ex(2'b00, 3'd2, 1'b0, 2'b01));
    step("rr_dst0",  2'b11, ex(2'b00, 3'd2, 1'b0, 2'b00));
    step("rr_grant1", 2'b11, ex(2'b10, 3'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 5; i++)
      step("rr_count1", 2'b11, ex(2'b10, 3'(i), 1'b1, 2'b00));
    step("rr_done1", 2'b11, ex(2'b00, 3'd5, 1'b0, 2'b10));
    step("rr_dst1",  2'b00, ex(2'b00, 3'd5, 1'b0, 2'b00));
    step("rr_idle",  2'b00, ex(2'b00, 3'd5, 1'b0, 2'b00));

    // Abort: TC0=7, req dropped at q=4.
    tc0 = 3'd7;
    step("abort_grant", 2'b01, ex(2'b01, 3'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 4; i++)
      step("abort_count", 2'b01, ex(2'b01, 3'(i), 1'b1, 2'b00));
    step("abort_edge", 2'b00, ex(2'b00, 3'd0, 1'b0, 2'b00));
    step("abort_idle", 2'b00, ex(2'b00, 3'd0, 1'b0, 2'b00));

    // Full-range run to q=7 with no wrap.
    step("max_grant", 2'b01, ex(2'b01, 3'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 7; i++)
      step("max_count", 2'b01, ex(2'b01, 3'(i), 1'b1, 2'b00));
    step("max_done", 2'b01, ex(2'b00, 3'd7, 1'b0, 2'b01));
    step("max_dst",  2'b00, ex(2'b00, 3'd7, 1'b0, 2'b00));

    // Reset mid-run at q=3.
    tc0 = 3'd6;
    step("rst_grant", 2'b01, ex(2'b01, 3'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 3; i++)
      step("rst_count", 2'b01, ex(2'b01, 3'(i), 1'b1, 2'b00));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {gnt, q, busy, done}, ex(2'b00, 3'd0, 1'b0, 2'b00));
    req = 2'b00;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      step("rst_no_done", 2'b00, ex(2'b00, 3'd0, 1'b0, 2'b00));

    // After reset, requester 0 wins the first tie.
    tc0 = 3'd1; tc1 = 3'd1;
    step("tie_grant", 2'b11, ex(2'b01, 3'd0, 1'b1, 2'b00));
    step("tie_count", 2'b11, ex(2'b01, 3'd1, 1'b1, 2'b00));
    step("tie_done",  2'b11, ex(2'b00, 3'd1, 1'b0, 2'b01));
    step("tie_dst",   2'b00, ex(2'b00, 3'd1, 1'b0, 2'b00));

`ifdef CNT_PAUSE_EN
    // Pause at q=2 for 3 cycles with TC0=4. Pause in IDLE and DONE_ST is
    // ignored.
    tc0 = 3'd4;
    pause = 1'b1;
    step("pause_idle_grant", 2'b01, ex(2'b01, 3'd0, 1'b1, 2'b00));
    pause = 1'b0;
    for (int i = 1; i <= 2; i++)
      step("pause_count", 2'b01, ex(2'b01, 3'(i), 1'b1, 2'b00));
    pause = 1'b1;
    for (int i = 0; i < 3; i++)
      step("pause_hold", 2'b01, ex(2'b01, 3'd2, 1'b1, 2'b00));
    pause = 1'b0;
    for (int i = 3; i <= 4; i++)
      step("pause_resume", 2'b01, ex(2'b01, 3'(i), 1'b1, 2'b00));
    step("pause_done", 2'b01, ex(2'b00, 3'd4, 1'b0, 2'b01));
    pause = 1'b1;
    step("pause_dst", 2'b00, ex(2'b00, 3'd4, 1'b0, 2'b00));
    step("pause_idle", 2'b00, ex(2'b00, 3'd4, 1'b0, 2'b00));
    pause = 1'b0;
`endif

    // Let the monitor drain the queue.
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ch2_cnt_ctrl.md
CH2_CNT_CTRL -- requirements
Module: CH2_CNT_CTRL

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single clock; every flop updates on the falling edge of CLK.
REQ-002 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port REQ, input, 2 bits: per-requester count-run request, level-sensitive, held high until DONE is seen.
REQ-004 The block SHALL have port TC0, input, 3 bits: terminal count for requester 0, sampled only on the grant edge.
REQ-005 The block SHALL have port TC1, input, 3 bits: terminal count for requester 1, sampled only on the grant edge.
REQ-006 The block SHALL have port PAUSE, input, 1 bit: count freeze; the port exists only when CNT_PAUSE_EN is defined.
REQ-007 The block SHALL have port GNT, output, 2 bits: one-hot owner of the shared counter, or 2'b00 when there is no owner.
REQ-008 The block SHALL have port Q, output, 3 bits: the shared counter value.
REQ-009 The block SHALL have port BUSY, output, 1 bit: high while the state is RUN.
REQ-010 The block SHALL have port DONE, output, 2 bits: one-cycle completion pulse for each requester.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and DONE_ST.
REQ-012 In IDLE with REQ != 0, the next edge SHALL grant exactly one requester and apply all of the following:
  - set GNT one-hot;
  - set Q to 0;
  - latch the granted requester's TCx into an internal 3-bit TCL;
  - go to RUN.
REQ-013 Arbitration SHALL be round-robin: when both REQ bits are high, the grant goes to the requester not served last; a sole requester always wins.
REQ-014 The last-served pointer SHALL reset to requester 1, so requester 0 wins the first tie.
REQ-015 In RUN with the owner's REQ high and Q != TCL, each edge SHALL increment Q by 1.
REQ-016 In RUN with Q == TCL, the next edge SHALL apply all of the following:
  - hold Q;
  - clear GNT;
  - drive DONE[owner]=1;
  - go to DONE_ST.
REQ-017 A run SHALL therefore spend TCL+1 cycles in RUN; TCx=0 gives one RUN cycle with Q=0.
REQ-018 Q SHALL never wrap: the maximum TCL is 7 and it ends the run at Q=7.
REQ-019 DONE_ST SHALL last exactly one cycle: the next edge clears DONE and goes to IDLE.
REQ-020 A requester still holding REQ in IDLE after DONE_ST SHALL be treated as a new request.
REQ-021 If the owner drops REQ during RUN, the next edge SHALL abort the run: GNT=0, Q=0, no DONE pulse, state IDLE; the last-served pointer updates to that owner.
REQ-022 A change on TC0 or TC1 during RUN SHALL have no effect on the current run.
REQ-023 Requests from the non-owner during RUN or DONE_ST SHALL be ignored until IDLE.
REQ-024 GNT, BUSY and DONE SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-025 RST high SHALL immediately force all of the following, independent of CLK:
  - state IDLE;
  - Q=3'b000, GNT=2'b00, DONE=2'b00, BUSY=0;
  - TCL=0;
  - last-served pointer to requester 1.
REQ-026 Reset asserted mid-run SHALL abandon the run with no DONE pulse; operation resumes on the first falling edge after RST falls.

Configuration
REQ-027 The macro CNT_PAUSE_EN SHALL control the pause feature.
REQ-028 With CNT_PAUSE_EN defined, PAUSE=1 in RUN SHALL hold Q and suppress the terminal-count check; GNT and BUSY stay asserted; the abort of REQ-021 still takes priority.
REQ-029 With CNT_PAUSE_EN defined, PAUSE SHALL be ignored in IDLE and DONE_ST.
REQ-030 Without CNT_PAUSE_EN, the PAUSE port and its logic SHALL be absent and RUN SHALL never stall.

Verification
REQ-031 The bench SHALL cover: RST pulse mid-run with Q=3 -> Q=0, GNT=00 and DONE=00 at once, with no DONE pulse afterwards.
REQ-032 The bench SHALL cover: REQ=01, TC0=3 -> GNT=01; Q runs 0,1,2,3 over 4 cycles; DONE=01 for one cycle; GNT=00.
REQ-033 The bench SHALL cover: REQ=11 held for two full runs, TC0=2, TC1=5 -> requester 0 granted first, then requester 1; Q reaches 2, then 5.
REQ-034 The bench SHALL cover: REQ=10, TC1=0 -> one RUN cycle with Q=0, then DONE=10.
REQ-035 The bench SHALL cover: REQ=01, TC0=7, REQ[0] dropped at Q=4 -> next edge Q=0, GNT=00, DONE stays 00.
REQ-036 The bench SHALL cover, with CNT_PAUSE_EN: TC0=4, PAUSE high for 3 cycles at Q=2 -> Q holds at 2 for 3 cycles; DONE arrives 3 cycles later than without pause.
